// File: rtl/merge2_run_reader.sv
// rtl/merge2_run_reader.sv - two-run merge reader over FIFO peek/pop ports
// Build option MERGE_DESCEND_EN: merge descending runs instead of ascending ones.
module merge2_run_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_RUN   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  a_empty,
    input  logic [DATA_WIDTH-1:0] a_dcmp,
    output logic                  a_rd_en,
    input  logic                  b_empty,
    input  logic [DATA_WIDTH-1:0] b_dcmp,
    output logic                  b_rd_en,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int                RUN_LEN_I = 1 << LOG2_RUN;
    localparam int                LAST_I    = RUN_LEN_I - 1;
    localparam logic [LOG2_RUN:0] RUN_LEN   = RUN_LEN_I[LOG2_RUN:0];
    localparam logic [LOG2_RUN:0] LAST      = LAST_I[LOG2_RUN:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_MERGE,
        S_DRAIN_A,
        S_DRAIN_B,
        S_DONE
    } state_t;

    state_t            state, state_next;
    logic [LOG2_RUN:0] cnt_a, cnt_b;
    logic              clear_cnt;
    logic              a_first;

    // Ties always favour A so equal keys keep their run order.
`ifdef MERGE_DESCEND_EN
    assign a_first = (a_dcmp >= b_dcmp);
`else
    assign a_first = (a_dcmp <= b_dcmp);
`endif

    always_comb begin
        state_next = state;
        a_rd_en    = 1'b0;
        b_rd_en    = 1'b0;
        clear_cnt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_MERGE;
                    clear_cnt  = 1'b1;
                end
            end
            S_MERGE: begin
                if (out_ready && !a_empty && !b_empty) begin
                    if (a_first) begin
                        a_rd_en = 1'b1;
                        if (cnt_a == LAST) state_next = S_DRAIN_B;
                    end else begin
                        b_rd_en = 1'b1;
                        if (cnt_b == LAST) state_next = S_DRAIN_A;
                    end
                end
            end
            S_DRAIN_A: begin
                if (cnt_a == RUN_LEN) state_next = S_DONE;
                else                  a_rd_en    = out_ready & ~a_empty;
            end
            S_DRAIN_B: begin
                if (cnt_b == RUN_LEN) state_next = S_DONE;
                else                  b_rd_en    = out_ready & ~b_empty;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // No pops may leak out while reset is held.
        if (reset) begin
            a_rd_en = 1'b0;
            b_rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt_a     <= '0;
            cnt_b     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= a_rd_en | b_rd_en;
            if (clear_cnt) begin
                cnt_a <= '0;
                cnt_b <= '0;
            end else begin
                if (a_rd_en) cnt_a <= cnt_a + 1'b1;
                if (b_rd_en) cnt_b <= cnt_b + 1'b1;
            end
            if (a_rd_en)      out_data <= a_dcmp;
            else if (b_rd_en) out_data <= b_dcmp;
        end
    end

    assign busy = (state == S_MERGE) || (state == S_DRAIN_A) || (state == S_DRAIN_B);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_merge2_run_reader.sv
// tb/tb_merge2_run_reader.sv - scoreboard bench for merge2_run_reader
// Honours MERGE_DESCEND_EN the same way as the design.
module tb_merge2_run_reader;

    localparam int DW = 32;
    localparam int LR = 3;
    localparam int RL = 1 << LR;

    logic          clk = 1'b0;
    logic          reset, start, out_ready;
    logic          a_empty, b_empty;
    logic [DW-1:0] a_dcmp, b_dcmp;
    logic          a_rd_en, b_rd_en;
    logic [DW-1:0] out_data;
    logic          out_valid, busy, done;

    merge2_run_reader #(.DATA_WIDTH(DW), .LOG2_RUN(LR)) dut (
        .clk(clk), .reset(reset), .start(start),
        .a_empty(a_empty), .a_dcmp(a_dcmp), .a_rd_en(a_rd_en),
        .b_empty(b_empty), .b_dcmp(b_dcmp), .b_rd_en(b_rd_en),
        .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fa[$], fb[$], exp_q[$];
    logic [DW-1:0] ra[RL], rb[RL];
    logic [DW-1:0] last_exp = '0;
    int  compared = 0, mismatched = 0;
    int  pops = 0, a_before_b = 0, outs = 0;
    int  cyc_n = 0, last_strobe = 0;
    bit  b_seen = 0, done_seen = 0, b_hold = 0;
    bit  a_pop_s = 0, b_pop_s = 0, prev_pop = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // FIFO head view, refreshed shortly after each falling edge.
    always @(negedge clk) begin
        #1;
        a_empty = (fa.size() == 0);
        a_dcmp  = (fa.size() != 0) ? fa[0] : '0;
        b_empty = b_hold || (fb.size() == 0);
        b_dcmp  = (fb.size() != 0) ? fb[0] : '0;
    end

    // Pop strobes are sampled well before the rising edge that acts on them.
    always @(negedge clk) begin
        #2;
        a_pop_s = a_rd_en;
        b_pop_s = b_rd_en;
        if (reset) check("rd_en_in_reset", {a_rd_en, b_rd_en}, 2'b00);
        if (a_rd_en || b_rd_en) begin
            check("rd_en_exclusive", a_rd_en & b_rd_en, 1'b0);
            check("pop_while_empty", (a_rd_en & a_empty) | (b_rd_en & b_empty), 1'b0);
            check("pop_without_ready", out_ready, 1'b1);
        end
    end

    always @(posedge clk) begin
        cyc_n++;
        prev_pop = a_pop_s | b_pop_s;
        if (a_pop_s) begin
            void'(fa.pop_front());
            pops++;
            if (!b_seen) a_before_b++;
        end
        if (b_pop_s) begin
            void'(fb.pop_front());
            pops++;
            b_seen = 1;
        end
    end

    always @(posedge clk) begin
        #1;
        check("out_valid_latency", out_valid, prev_pop);
        if (out_valid) begin
            outs++;
            last_strobe = cyc_n;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_strobe: got %0h, expected no strobe", out_data);
            end else begin
                last_exp = exp_q.pop_front();
                check("out_data", out_data, last_exp);
            end
        end else begin
            check("out_data_hold", out_data, last_exp);
        end
        if (done) begin
            done_seen = 1;
            check("busy_low_at_done", busy, 1'b0);
            check("done_gap_after_last_strobe", cyc_n - last_strobe, 1);
        end
    end

    task automatic order_runs();
        logic [DW-1:0] qa[$], qb[$];
        for (int i = 0; i < RL; i++) begin
            qa.push_back(ra[i]);
            qb.push_back(rb[i]);
        end
`ifdef MERGE_DESCEND_EN
        qa.rsort();
        qb.rsort();
`else
        qa.sort();
        qb.sort();
`endif
        for (int i = 0; i < RL; i++) begin
            ra[i] = qa[i];
            rb[i] = qb[i];
        end
    endtask

    task automatic run_pass(input int mode, input bit hold_b, input bit a_first, input int abort_after);
        logic [DW-1:0] all[$];
        bit aborted;
        order_runs();
        fa.delete();
        fb.delete();
        exp_q.delete();
        for (int i = 0; i < RL; i++) begin
            fa.push_back(ra[i]);
            fb.push_back(rb[i]);
            all.push_back(ra[i]);
            all.push_back(rb[i]);
        end
        // Merged result of two ordered runs is just their combined order.
        all.sort();
`ifdef MERGE_DESCEND_EN
        all.reverse();
`endif
        exp_q = all;
        pops = 0; a_before_b = 0; b_seen = 0; outs = 0; done_seen = 0; aborted = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        check("busy_after_start", busy, 1'b1);
        for (int cyc = 0; cyc < 600 && !done_seen; cyc++) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc / 3) % 2) == 0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            b_hold = hold_b && (cyc >= 4) && (cyc < 14);
            start  = (cyc == 7);
            if (abort_after > 0 && pops >= abort_after) begin
                start = 0; b_hold = 0; reset = 1; last_exp = '0;
                @(negedge clk);
                check("abort_pop_count", pops, abort_after);
                check("reset_outputs", {out_valid, busy, done, out_data}, '0);
                reset = 0;
                exp_q.delete();
                aborted = 1;
                break;
            end
            @(negedge clk);
        end
        start = 0;
        b_hold = 0;
        out_ready = 1;
        if (!aborted) begin
            check("done_seen", done_seen, 1'b1);
            check("strobe_count", outs, 2 * RL);
            check("expected_drained", exp_q.size(), 0);
            if (a_first) check("a_pops_before_b", a_before_b, RL);
            if (done_seen) begin
                start = 1;
                @(negedge clk);
                start = 0;
                check("done_single_cycle", done, 1'b0);
                check("start_in_done_ignored", busy, 1'b0);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1; start = 0; out_ready = 1;
        a_empty = 1; b_empty = 1; a_dcmp = '0; b_dcmp = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {out_valid, busy, done, out_data}, '0);
        reset = 0;
        @(negedge clk);

        for (int i = 0; i < RL; i++) begin ra[i] = 2 * i + 1; rb[i] = 2 * i + 2; end
        run_pass(0, 0, 0, 0);
`ifdef MERGE_DESCEND_EN
        for (int i = 0; i < RL; i++) begin ra[i] = i + 9; rb[i] = i + 1; end
`else
        for (int i = 0; i < RL; i++) begin ra[i] = i + 1; rb[i] = i + 9; end
`endif
        run_pass(0, 0, 1, 0);
        for (int i = 0; i < RL; i++) begin ra[i] = 5; rb[i] = 5; end
        run_pass(0, 0, 1, 0);
        for (int i = 0; i < RL; i++) begin ra[i] = $urandom_range(0, 15); rb[i] = $urandom_range(0, 15); end
        run_pass(1, 0, 0, 0);
        for (int i = 0; i < RL; i++) begin ra[i] = 2 * i + 1; rb[i] = 2 * i + 2; end
        run_pass(0, 1, 0, 0);
        run_pass(0, 0, 0, 5);
        for (int i = 0; i < RL; i++) begin ra[i] = 2 * i + 1; rb[i] = 2 * i + 2; end
        run_pass(0, 0, 0, 0);
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < RL; i++) begin
                ra[i] = (p % 2) ? $urandom() : $urandom_range(0, 15);
                rb[i] = (p % 2) ? $urandom() : $urandom_range(0, 15);
            end
            run_pass(2, p >= 3, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
